alarm_ctrl: RTL and testbench
=============================

// Module: alarm_ctrl
// PURPOSE
//  Alarm controller that sits upstream of the melody/beep player.
//  - Holds a validated BCD alarm time and compares it against the running BCD clock.
//  - Drives the player's active-low trigger open1 while the alarm rings.
//  - Handles stop, snooze and ring timeout.
// PARAMETERS
//  CLK_HZ      24_000_000  clk frequency; sets the 1 s ring-timer tick
//  RING_SEC    60          max ring duration in seconds before auto-stop (1..255)
//  SNOOZE_MIN  5           snooze delay in minutes (1..59)
// PORTS
//  clk            in   1   system clock, 24 MHz
//  rst            in   1   reset; asynchronous, active-high
//  time_num       in   24  current time, BCD {hh,mm,ss}, from the clock counter
//  alarm_set_vld  in   1   1-cycle strobe: load alarm_set_num
//  alarm_set_num  in   16  requested alarm, BCD {hh,mm}
//  alarm_en       in   1   level: alarm function enabled
//  stop_key       in   1   1-cycle debounced pulse: stop ringing / cancel snooze
//  snooze_key     in   1   1-cycle debounced pulse: snooze while ringing
//  open1          out  1   active-low ring request to the beep player
//  alarm_num      out  16  currently stored alarm, BCD {hh,mm}
//  ringing        out  1   high in RINGING
//  snoozed        out  1   high in SNOOZE
//  set_err        out  1   1-cycle pulse: rejected alarm_set_num
// BEHAVIOUR
//  Reset values:
//   - alarm_num = 16'h0700, target = 16'h0700, state = IDLE.
//   - open1 = 1, ringing = snoozed = set_err = 0; all counters 0.
//  Set: on alarm_set_vld the value is checked for valid BCD digits, hh <= 23, mm <= 59.
//   - Valid: alarm_num and target load next cycle. If RINGING or SNOOZE, go to ARMED,
//     or to IDLE when alarm_en = 0.
//   - Invalid: set_err pulses 1 cycle; alarm_num is unchanged.
//  Match: match = (time_num[23:8] == target) && (time_num[7:0] == 8'h00).
//   - Registered copy match_d; the trigger is the rising edge match & ~match_d.
//   - Fires exactly once per matching minute.
//  FSM:
//   - IDLE:    alarm_en=1 -> ARMED.
//   - ARMED:   trigger -> RINGING (sec_cnt=0, tick_cnt=0); alarm_en=0 -> IDLE.
//   - RINGING: open1 = 0.
//       stop_key -> ARMED, target = alarm_num.
//       snooze_key -> SNOOZE, target = alarm_num + snooze_count*SNOOZE_MIN, as below.
//       sec_cnt reaches RING_SEC -> ARMED, target = alarm_num.
//       alarm_en=0 -> IDLE.
//   - SNOOZE:  open1 = 1. trigger on target -> RINGING.
//       stop_key or alarm_en=0 -> ARMED/IDLE, target = alarm_num.
//  Snooze arithmetic: target_next = current target + SNOOZE_MIN minutes, in BCD.
//   - Minutes wrap 59->00 with carry into hours; hours wrap 23->00.
//   - Example: 23:58 + 5 -> 00:03.
//  Ring timer: tick_cnt counts 0..CLK_HZ-1 and then increments sec_cnt.
//   - Both counters are cleared outside RINGING.
//  Output timing:
//   - open1 and ringing are registered; they assert 1 cycle after the trigger
//     edge and deassert 1 cycle after stop, snooze or timeout.
//   - The player latches its 16 s melody on open1 low. After a melody ends, open1
//     still low restarts it, so ringing repeats until RINGING exits.
//  Priority in one cycle: rst > alarm_en=0 > valid set > stop_key > snooze_key > timeout > trigger.
//  Other cases:
//   - stop_key or snooze_key in IDLE/ARMED: ignored.
//   - snooze_key in SNOOZE: ignored.
//   - time_num stepped backward or forward across the target: only a fresh rising
//     match edge triggers, so there is no retroactive ring.
//   - rst mid-ring: open1 returns high immediately (asynchronous).
// TESTING
//  1. alarm_set 16'h0630, alarm_en=1, time_num steps 06:29:59 -> 06:30:00
//     -> open1 low and ringing=1 one cycle later; 06:30:01 causes no re-trigger.
//  2. Ringing, stop_key pulse -> open1 high next cycle, state ARMED, target 16'h0630;
//     the next day's 06:30:00 rings again.
//  3. Alarm 23:58 ringing, snooze_key -> snoozed=1, target 16'h0003;
//     time 00:03:00 -> RINGING.
//  4. Ring with no key press, RING_SEC=2 and CLK_HZ=10 in sim
//     -> open1 high after 20 cycles, state ARMED.
//  5. alarm_set_num 16'h2460, then 16'h1A00
//     -> set_err pulses each time and alarm_num is unchanged.
//  6. stop_key and snooze_key in the same cycle -> ARMED (stop wins);
//     rst asserted mid-ring -> open1=1 with no clock edge.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm controller upstream of the melody/beep player.
// Holds a validated BCD alarm time, compares it with the running BCD clock and
// drives the player's active-low ring request while ringing. Handles stop,
// snooze (cumulative, BCD minute/hour wrap) and an automatic ring timeout.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   time_num       current time, BCD {hh,mm,ss}
//   alarm_set_vld  1-cycle strobe: load alarm_set_num
//   alarm_set_num  requested alarm, BCD {hh,mm}
//   alarm_en       level: alarm function enabled
//   stop_key       1-cycle pulse: stop ringing / cancel snooze
//   snooze_key     1-cycle pulse: snooze while ringing
//   open1          active-low ring request to the player
//   alarm_num      stored alarm, BCD {hh,mm}
//   ringing        high while ringing
//   snoozed        high while snoozed
//   set_err        1-cycle pulse: rejected alarm_set_num
module alarm_ctrl #(
  parameter int unsigned CLK_HZ     = 24_000_000,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] time_num,
  input  logic        alarm_set_vld,
  input  logic [15:0] alarm_set_num,
  input  logic        alarm_en,
  input  logic        stop_key,
  input  logic        snooze_key,
  output logic        open1,
  output logic [15:0] alarm_num,
  output logic        ringing,
  output logic        snoozed,
  output logic        set_err
);

  localparam int unsigned TickW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  typedef enum logic [1:0] {StIdle, StArmed, StRinging, StSnooze} state_e;

  state_e           state_q, state_d;
  logic [15:0]      alarm_q, alarm_d;
  logic [15:0]      target_q, target_d;
  logic             match_q;
  logic             set_err_q;
  logic [TickW-1:0] tick_q, tick_d;
  logic [7:0]       sec_q, sec_d;

  logic match, trigger, set_ok, timeout;

  function automatic logic bcd_valid(input logic [15:0] v);
    logic hh_ok, mm_ok;
    hh_ok = ((v[15:12] < 4'd2) && (v[11:8] <= 4'd9)) ||
            ((v[15:12] == 4'd2) && (v[11:8] <= 4'd3));
    mm_ok = (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    return hh_ok && mm_ok;
  endfunction

  // Adds SNOOZE_MIN minutes to a valid BCD {hh,mm}, wrapping 23:59 -> 00:00.
  function automatic logic [15:0] add_snooze(input logic [15:0] t);
    logic [6:0] hr;
    logic [7:0] mn;
    hr = ({3'b000, t[15:12]} * 7'd10) + {3'b000, t[11:8]};
    mn = ({4'h0, t[7:4]} * 8'd10) + {4'h0, t[3:0]} + 8'(SNOOZE_MIN);
    if (mn >= 8'd60) begin
      mn = mn - 8'd60;
      hr = (hr == 7'd23) ? 7'd0 : hr + 7'd1;
    end
    return {4'(hr / 7'd10), 4'(hr % 7'd10), 4'(mn / 8'd10), 4'(mn % 8'd10)};
  endfunction

  assign match   = (time_num[23:8] == target_q) && (time_num[7:0] == 8'h00);
  assign trigger = match & ~match_q;
  assign set_ok  = alarm_set_vld & bcd_valid(alarm_set_num);
  // Fires on the last tick of the final second so the ring lasts RING_SEC*CLK_HZ cycles.
  assign timeout = (tick_q == TickW'(CLK_HZ - 1)) && (sec_q == 8'(RING_SEC - 1));

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    alarm_d  = alarm_q;
    if (!alarm_en) begin
      state_d = StIdle;
      if (state_q == StRinging || state_q == StSnooze) target_d = alarm_q;
    end else begin
      case (state_q)
        StIdle:  state_d = StArmed;
        StArmed: if (!set_ok && trigger) state_d = StRinging;
        StRinging: begin
          if (set_ok) begin
            state_d = StArmed;
          end else if (stop_key) begin
            state_d  = StArmed;
            target_d = alarm_q;
          end else if (snooze_key) begin
            state_d  = StSnooze;
            target_d = add_snooze(target_q);
          end else if (timeout) begin
            state_d  = StArmed;
            target_d = alarm_q;
          end
        end
        StSnooze: begin
          if (set_ok) begin
            state_d = StArmed;
          end else if (stop_key) begin
            state_d  = StArmed;
            target_d = alarm_q;
          end else if (trigger) begin
            state_d = StRinging;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    // A valid set always reloads both the stored alarm and the compare target.
    if (set_ok) begin
      alarm_d  = alarm_set_num;
      target_d = alarm_set_num;
    end
  end

  // Ring timer only runs while staying in RINGING; cleared otherwise.
  always_comb begin
    tick_d = '0;
    sec_d  = '0;
    if (state_q == StRinging && state_d == StRinging) begin
      if (tick_q == TickW'(CLK_HZ - 1)) begin
        sec_d = sec_q + 8'd1;
      end else begin
        tick_d = tick_q + TickW'(1);
        sec_d  = sec_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      alarm_q   <= 16'h0700;
      target_q  <= 16'h0700;
      match_q   <= 1'b0;
      set_err_q <= 1'b0;
      tick_q    <= '0;
      sec_q     <= '0;
    end else begin
      state_q   <= state_d;
      alarm_q   <= alarm_d;
      target_q  <= target_d;
      match_q   <= match;
      set_err_q <= alarm_set_vld & ~bcd_valid(alarm_set_num);
      tick_q    <= tick_d;
      sec_q     <= sec_d;
    end
  end

  assign ringing   = (state_q == StRinging);
  assign snoozed   = (state_q == StSnooze);
  assign open1     = ~ringing;
  assign alarm_num = alarm_q;
  assign set_err   = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
module tb_alarm_ctrl;
  localparam int unsigned CLK_HZ     = 10;
  localparam int unsigned RING_SEC   = 2;
  localparam int unsigned SNOOZE_MIN = 5;

  logic        clk, rst;
  logic [23:0] time_num;
  logic        alarm_set_vld;
  logic [15:0] alarm_set_num;
  logic        alarm_en, stop_key, snooze_key;
  logic        open1, ringing, snoozed, set_err;
  logic [15:0] alarm_num;

  int n_tests = 0;
  int n_fail  = 0;

  alarm_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .RING_SEC  (RING_SEC),
    .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .time_num     (time_num),
    .alarm_set_vld(alarm_set_vld),
    .alarm_set_num(alarm_set_num),
    .alarm_en     (alarm_en),
    .stop_key     (stop_key),
    .snooze_key   (snooze_key),
    .open1        (open1),
    .alarm_num    (alarm_num),
    .ringing      (ringing),
    .snoozed      (snoozed),
    .set_err      (set_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: minutes-of-day for alarm/target, ring length in cycles.
  int m_mode;  // 0 idle, 1 armed, 2 ringing, 3 snoozed
  int m_alarm, m_tgt, m_rc;
  bit m_prev, m_err;
  int tsec;

  function automatic logic [7:0] bcd2(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [23:0] hms(input int h, input int m, input int s);
    return {bcd2(h), bcd2(m), bcd2(s)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_time(input logic [23:0] t);
    time_num = t;
    tick();
  endtask

  task automatic pulse_set(input logic [15:0] v);
    alarm_set_vld = 1'b1;
    alarm_set_num = v;
    tick();
    alarm_set_vld = 1'b0;
  endtask

  task automatic press(input logic stop, input logic snooze);
    stop_key   = stop;
    snooze_key = snooze;
    tick();
    stop_key   = 1'b0;
    snooze_key = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alarm_en = 1'b0; alarm_set_vld = 1'b0; alarm_set_num = '0;
    stop_key = 1'b0; snooze_key = 1'b0; time_num = hms(0, 0, 1);
    tick();
    n_tests++;
    if (open1 !== 1'b1 || ringing !== 1'b0 || snoozed !== 1'b0 || set_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: open1=%b ringing=%b snoozed=%b set_err=%b, want 1 0 0 0",
               open1, ringing, snoozed, set_err);
    end
    n_tests++;
    if (alarm_num !== 16'h0700) begin
      n_fail++;
      $display("FAIL reset_alarm_num: got %h want 0700", alarm_num);
    end
    rst = 1'b0;
  endtask

  task automatic test_set_ring();
    alarm_en = 1'b1;
    step_time(hms(6, 29, 58));
    pulse_set(16'h0630);
    n_tests++;
    if (alarm_num !== 16'h0630) begin
      n_fail++;
      $display("FAIL set_load: alarm_num=%h want 0630", alarm_num);
    end
    step_time(hms(6, 29, 59));
    n_tests++;
    if (ringing !== 1'b0 || open1 !== 1'b1) begin
      n_fail++;
      $display("FAIL early_ring: ringing=%b open1=%b want 0 1", ringing, open1);
    end
    step_time(hms(6, 30, 0));
    n_tests++;
    if (ringing !== 1'b1 || open1 !== 1'b0) begin
      n_fail++;
      $display("FAIL ring_start: ringing=%b open1=%b want 1 0", ringing, open1);
    end
    step_time(hms(6, 30, 1));
    n_tests++;
    if (ringing !== 1'b1) begin
      n_fail++;
      $display("FAIL ring_hold: ringing=%b want 1", ringing);
    end
  endtask

  task automatic test_stop();
    press(1'b1, 1'b0);
    n_tests++;
    if (open1 !== 1'b1 || ringing !== 1'b0 || snoozed !== 1'b0) begin
      n_fail++;
      $display("FAIL stop: open1=%b ringing=%b snoozed=%b want 1 0 0", open1, ringing, snoozed);
    end
    step_time(hms(6, 30, 2));
    n_tests++;
    if (ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL no_retrigger: ringing=%b want 0", ringing);
    end
    step_time(hms(6, 29, 59));
    step_time(hms(6, 30, 0));
    n_tests++;
    if (ringing !== 1'b1) begin
      n_fail++;
      $display("FAIL next_day_ring: ringing=%b want 1", ringing);
    end
    press(1'b1, 1'b0);
  endtask

  task automatic test_snooze();
    pulse_set(16'h2358);
    step_time(hms(23, 57, 59));
    step_time(hms(23, 58, 0));
    press(1'b0, 1'b1);
    n_tests++;
    if (snoozed !== 1'b1 || ringing !== 1'b0 || open1 !== 1'b1) begin
      n_fail++;
      $display("FAIL snooze_enter: snoozed=%b ringing=%b open1=%b want 1 0 1",
               snoozed, ringing, open1);
    end
    step_time(hms(0, 2, 59));
    n_tests++;
    if (snoozed !== 1'b1 || ringing !== 1'b0) begin
      n_fail++;
      $display("FAIL snooze_hold: snoozed=%b ringing=%b want 1 0", snoozed, ringing);
    end
    step_time(hms(0, 3, 0));
    n_tests++;
    if (ringing !== 1'b1 || snoozed !== 1'b0) begin
      n_fail++;
      $display("FAIL snooze_wrap_ring: ringing=%b snoozed=%b want 1 0", ringing, snoozed);
    end
    press(1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    step_time(hms(23, 57, 59));
    step_time(hms(23, 58, 0));
    n = 0;
    while (open1 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_tests++;
    if (n != int'(RING_SEC * CLK_HZ)) begin
      n_fail++;
      $display("FAIL timeout_len: ring cycles=%0d want %0d", n, RING_SEC * CLK_HZ);
    end
    tick();
    n_tests++;
    if (ringing !== 1'b0 || snoozed !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_state: ringing=%b snoozed=%b want 0 0", ringing, snoozed);
    end
    step_time(hms(23, 57, 59));
    step_time(hms(23, 58, 0));
    n_tests++;
    if (ringing !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_rearm: ringing=%b want 1", ringing);
    end
    press(1'b1, 1'b0);
  endtask

  task automatic test_set_err();
    pulse_set(16'h2460);
    n_tests++;
    if (set_err !== 1'b1 || alarm_num !== 16'h2358) begin
      n_fail++;
      $display("FAIL set_err_2460: set_err=%b alarm_num=%h want 1 2358", set_err, alarm_num);
    end
    tick();
    n_tests++;
    if (set_err !== 1'b0) begin
      n_fail++;
      $display("FAIL set_err_pulse: set_err=%b want 0", set_err);
    end
    pulse_set(16'h1A00);
    n_tests++;
    if (set_err !== 1'b1 || alarm_num !== 16'h2358) begin
      n_fail++;
      $display("FAIL set_err_1a00: set_err=%b alarm_num=%h want 1 2358", set_err, alarm_num);
    end
  endtask

  task automatic test_stop_wins();
    step_time(hms(23, 57, 59));
    step_time(hms(23, 58, 0));
    press(1'b1, 1'b1);
    n_tests++;
    if (ringing !== 1'b0 || snoozed !== 1'b0 || open1 !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_wins: ringing=%b snoozed=%b open1=%b want 0 0 1",
               ringing, snoozed, open1);
    end
  endtask

  task automatic test_rst_mid_ring();
    step_time(hms(23, 57, 59));
    step_time(hms(23, 58, 0));
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (open1 !== 1'b1 || ringing !== 1'b0 || alarm_num !== 16'h0700) begin
      n_fail++;
      $display("FAIL async_rst: open1=%b ringing=%b alarm_num=%h want 1 0 0700",
               open1, ringing, alarm_num);
    end
    tick();
  endtask

  task automatic test_random();
    int r, h1, h0, n1, n0, nmode, cyc;
    bit match, trig, ok, tout;
    logic [15:0] exp_alarm;
    m_mode = 0; m_alarm = 420; m_tgt = 420; m_rc = 0; m_prev = 0; m_err = 0;
    tsec = 7 * 3600;
    alarm_en = 1'b1;
    rst = 1'b0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      r = $urandom_range(0, 99);
      if (r < 3) tsec = $urandom_range(0, 86399);
      else if (r < 12) tsec = (m_tgt * 60 + 86400 - $urandom_range(0, 2)) % 86400;
      else tsec = (tsec + 1) % 86400;
      time_num = hms(tsec / 3600, (tsec / 60) % 60, tsec % 60);
      if (alarm_en) alarm_en = ($urandom_range(0, 63) != 0);
      else alarm_en = ($urandom_range(0, 3) == 0);
      alarm_set_vld = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 2))
        0: alarm_set_num = {bcd2($urandom_range(0, 23)), bcd2($urandom_range(0, 59))};
        1: alarm_set_num = 16'($urandom);
        default: alarm_set_num = {bcd2(tsec / 3600), bcd2(((tsec / 60) + 1) % 60)};
      endcase
      stop_key   = ($urandom_range(0, 29) == 0);
      snooze_key = ($urandom_range(0, 9) == 0);
      @(posedge clk);
      // Model step on the inputs just sampled.
      match = ((tsec / 60) == m_tgt) && ((tsec % 60) == 0);
      trig  = match && !m_prev;
      h1 = int'(alarm_set_num[15:12]); h0 = int'(alarm_set_num[11:8]);
      n1 = int'(alarm_set_num[7:4]);   n0 = int'(alarm_set_num[3:0]);
      ok = alarm_set_vld && h1 <= 9 && h0 <= 9 && n1 <= 9 && n0 <= 9 &&
           (h1 * 10 + h0) <= 23 && (n1 * 10 + n0) <= 59;
      tout = (m_mode == 2) && (m_rc == int'(RING_SEC * CLK_HZ) - 1);
      m_prev = match;
      m_err  = alarm_set_vld && !ok;
      nmode  = m_mode;
      if (!alarm_en) begin
        if (m_mode >= 2) m_tgt = m_alarm;
        nmode = 0;
      end else if (m_mode == 0) begin
        nmode = 1;
      end else if (m_mode == 1) begin
        if (!ok && trig) nmode = 2;
      end else if (m_mode == 2) begin
        if (ok) nmode = 1;
        else if (stop_key) begin nmode = 1; m_tgt = m_alarm; end
        else if (snooze_key) begin nmode = 3; m_tgt = (m_tgt + SNOOZE_MIN) % 1440; end
        else if (tout) begin nmode = 1; m_tgt = m_alarm; end
      end else begin
        if (ok) nmode = 1;
        else if (stop_key) begin nmode = 1; m_tgt = m_alarm; end
        else if (trig) nmode = 2;
      end
      if (ok) begin
        m_alarm = (h1 * 10 + h0) * 60 + n1 * 10 + n0;
        m_tgt   = m_alarm;
      end
      m_rc   = (m_mode == 2 && nmode == 2) ? m_rc + 1 : 0;
      m_mode = nmode;
      #1;
      exp_alarm = {bcd2(m_alarm / 60), bcd2(m_alarm % 60)};
      n_tests++;
      if (ringing !== (m_mode == 2) || snoozed !== (m_mode == 3) ||
          open1 !== (m_mode != 2) || set_err !== m_err || alarm_num !== exp_alarm) begin
        n_fail++;
        $display("FAIL random cyc %0d: ring=%b snz=%b open1=%b err=%b alarm=%h want %b %b %b %b %h",
                 cyc, ringing, snoozed, open1, set_err, alarm_num, (m_mode == 2),
                 (m_mode == 3), (m_mode != 2), m_err, exp_alarm);
      end
    end
  endtask

  initial begin
    test_reset();
    test_set_ring();
    test_stop();
    test_snooze();
    test_timeout();
    test_set_err();
    test_stop_wins();
    test_rst_mid_ring();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
